hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Pipeline hazard controller on the consumer side of the ID/EXE register. Reads the
//  destination/control fields leaving ID/EXE plus source regs of the instruction in ID.
//  Generates load-use stalls, taken-branch/jal flushes and registered forwarding selects
//  that align with the instruction entering EXE. Tracks MEM/WB destinations in an internal
//  2-deep scoreboard and keeps saturating stall/flush event counters.
// PARAMETERS
//  ASIZE     5   register address width
//  BR_FLUSH  2   cycles flush_if_id/flush_id_exe stay high after taken branch/jal (1..3)
//  CSIZE     16  width of event counters
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      synchronous reset, active-low (rst==0 resets)
//  id_valid      in   1      ID holds a real instruction
//  id_rs1        in   ASIZE  ID source reg 1
//  id_rs2        in   ASIZE  ID source reg 2
//  id_rs1_used   in   1      ID reads rs1
//  id_rs2_used   in   1      ID reads rs2
//  exe_waddr     in   ASIZE  ID/EXE waddr_out
//  exe_wen       in   1      ID/EXE wen_out
//  exe_memread   in   1      ID/EXE memread_out
//  exe_taken     in   1      branch in EXE resolved taken (branch_out & cond)
//  exe_jal       in   1      ID/EXE jal_out
//  stall_if_id   out  1      hold PC and IF/ID (combinational)
//  flush_if_id   out  1      zero IF/ID (combinational)
//  flush_id_exe  out  1      load bubble into ID/EXE next edge (combinational)
//  fwd_a         out  2      registered EXE operand-A select
//  fwd_b         out  2      registered EXE operand-B select
//  stall_cnt     out  CSIZE  saturating count of stall cycles
//  flush_cnt     out  CSIZE  saturating count of redirect events
// BEHAVIOUR
//  Reset (rst==0 at posedge): fwd_a/fwd_b=00, counters=0, flush counter=0, scoreboard
//   MEM/WB entries wen=0 waddr=0. Comb outputs then follow rules below (all 0 if inputs idle).
//  Match rule: rsX matches stage S iff rsX_used & S.wen & S.waddr==rsX & rsX!=0.
//  Load-use: id_valid & (rs1 or rs2 matches EXE) & exe_memread -> stall_if_id=1,
//   flush_id_exe=1 for that cycle. One-cycle stall only; next cycle load is in MEM.
//  Redirect: exe_taken|exe_jal -> flush_if_id=flush_id_exe=1 this cycle; flush counter
//   loaded with BR_FLUSH-1 and held flushes stay high while counter!=0, decrementing each
//   cycle. Redirect asserted while counter!=0 reloads counter (restart, no accumulation).
//  Priority: active flush overrides stall: stall_if_id=0 whenever flush_if_id=1.
//  Scoreboard shift every cycle (EXE never stalls): MEM<=EXE fields (wen forced 0 if
//   exe was flushed bubble is already wen=0 in ID/EXE); WB<=MEM.
//  Forward select computed per operand in ID, registered at posedge:
//   EXE match & !exe_memread -> 01 (EXE/MEM ALU result)
//   else MEM match -> 10 (MEM/WB result, incl. load data)
//   else 00 (register file). EXE match wins over MEM match.
//   If flush_id_exe=1 or !id_valid that cycle, registered value is 00.
//  WB-stage matches need no forward (regfile write-before-read); not reported.
//  stall_cnt +1 per cycle with stall_if_id=1; flush_cnt +1 per cycle a redirect input is
//   seen (not per held flush cycle). Both saturate at all-ones, never wrap.
//  Reset mid-operation: flush counter, fwd regs, scoreboard cleared same edge; any
//   pending flush window aborted.
//  Latency: stall/flush 0 cycles (comb); fwd_a/b 1 cycle (valid with instr in EXE).
// TESTING
//  lw r3 in EXE (memread,wen,waddr=3); ID add rs1=3 -> stall=1,flush_id_exe=1 one cycle;
//   next cycle no stall, fwd_a=10 after edge; stall_cnt=1.
//  add r4 in EXE; ID sub rs2=4 -> no stall, fwd_b=01 next cycle; fwd_a=00.
//  r5 written in EXE and MEM both; ID rs1=5 -> fwd_a=01 (EXE priority).
//  rs1=0 with exe_waddr=0,wen=1 -> no stall, fwd_a=00.
//  exe_taken 1 cycle, BR_FLUSH=2 -> flush_if_id=1 for 2 cycles, flush_cnt=1; coincident
//   load-use -> stall_if_id=0.
//  stall_cnt preset near max via 2^CSIZE stalls (CSIZE=4) -> holds 15; rst=0 mid-flush
//   -> flushes drop next cycle, counters 0.

Source files
------------

// File: rtl/hazard_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_unit_if
//   Bundle of the hazard controller's pipeline-facing signals. The pipeline
//   (or a testbench) drives it through the master modport. The hazard unit
//   consumes it through the slave modport.
//
//   Pipeline -> hazard unit
//     id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used : instruction in ID
//     exe_waddr, exe_wen, exe_memread, exe_jal           : fields leaving ID/EXE
//     exe_taken                                          : branch in EXE taken
//   Hazard unit -> pipeline
//     stall_if_id, flush_if_id, flush_id_exe             : combinational controls
//     fwd_a, fwd_b                                       : registered operand selects
//     stall_cnt, flush_cnt                               : saturating event counters
// -----------------------------------------------------------------------------
interface hazard_unit_if #(
    parameter int ASIZE = 5,
    parameter int CSIZE = 16
);
    logic             id_valid;
    logic [ASIZE-1:0] id_rs1;
    logic [ASIZE-1:0] id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [ASIZE-1:0] exe_waddr;
    logic             exe_wen;
    logic             exe_memread;
    logic             exe_taken;
    logic             exe_jal;

    logic             stall_if_id;
    logic             flush_if_id;
    logic             flush_id_exe;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CSIZE-1:0] stall_cnt;
    logic [CSIZE-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               exe_waddr, exe_wen, exe_memread, exe_taken, exe_jal,
        input  stall_if_id, flush_if_id, flush_id_exe,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               exe_waddr, exe_wen, exe_memread, exe_taken, exe_jal,
        output stall_if_id, flush_if_id, flush_id_exe,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//   Pipeline hazard controller sitting on the consumer side of ID/EXE.
//   - Load-use: stalls IF/ID and inserts a bubble into ID/EXE for one cycle
//     when the instruction in ID reads the destination of a load in EXE.
//   - Redirect: a taken branch or jal in EXE flushes IF/ID and ID/EXE for
//     BR_FLUSH cycles. A new redirect restarts the window. Flush beats stall.
//   - Forwarding: per-operand selects computed in ID and registered, so they
//     line up with the instruction once it reaches EXE.
//       00 register file, 01 EXE/MEM ALU result, 10 MEM/WB result.
//   - Saturating counters of stall cycles and redirect events.
//
//   Ports
//     clk : rising-edge clock
//     rst : synchronous reset, active low
//     hz  : hazard_unit_if.slave (pipeline fields in, hazard controls out)
// -----------------------------------------------------------------------------
module hazard_unit #(
    parameter int ASIZE    = 5,
    parameter int BR_FLUSH = 2,   // 1..3
    parameter int CSIZE    = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave hz
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXE = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Extra held cycles after the redirect cycle itself.
    localparam logic [1:0]       FLUSH_RELOAD = 2'(BR_FLUSH - 1);
    localparam logic [CSIZE-1:0] CNT_MAX      = '1;

    // A source depends on a stage only if it is read, the stage writes a
    // register, the addresses agree and the register is not the hardwired r0.
    function automatic logic src_match(
        input logic             used,
        input logic [ASIZE-1:0] rs,
        input logic             wen,
        input logic [ASIZE-1:0] waddr
    );
        return used && wen && (waddr == rs) && (rs != '0);
    endfunction

    // The nearest producer wins. A load still in EXE cannot forward; that case
    // is always a load-use stall, whose bubble forces the select to 00 anyway.
    function automatic logic [1:0] fwd_sel(
        input logic exe_hit,
        input logic mem_hit,
        input logic exe_load
    );
        if (exe_hit && !exe_load) begin
            return FWD_EXE;
        end else if (mem_hit) begin
            return FWD_MEM;
        end else begin
            return FWD_RF;
        end
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // MEM entry of the scoreboard: the instruction that was in EXE last cycle.
    // The WB entry is not kept. A WB-stage producer needs no forwarding because
    // the register file writes before it reads.
    logic             mem_wen_q,     mem_wen_d;
    logic [ASIZE-1:0] mem_waddr_q,   mem_waddr_d;
    logic [1:0]       flush_left_q,  flush_left_d;
    logic [1:0]       fwd_a_q,       fwd_a_d;
    logic [1:0]       fwd_b_q,       fwd_b_d;
    logic [CSIZE-1:0] stall_cnt_q,   stall_cnt_d;
    logic [CSIZE-1:0] flush_cnt_q,   flush_cnt_d;

    // ------------------------------------------------------------------
    // Dependency detection
    // ------------------------------------------------------------------
    logic rs1_exe_hit;
    logic rs2_exe_hit;
    logic rs1_mem_hit;
    logic rs2_mem_hit;
    logic load_use;
    logic redirect;
    logic flush_active;

    assign rs1_exe_hit = src_match(hz.id_rs1_used, hz.id_rs1, hz.exe_wen, hz.exe_waddr);
    assign rs2_exe_hit = src_match(hz.id_rs2_used, hz.id_rs2, hz.exe_wen, hz.exe_waddr);
    assign rs1_mem_hit = src_match(hz.id_rs1_used, hz.id_rs1, mem_wen_q, mem_waddr_q);
    assign rs2_mem_hit = src_match(hz.id_rs2_used, hz.id_rs2, mem_wen_q, mem_waddr_q);

    assign load_use     = hz.id_valid && hz.exe_memread && (rs1_exe_hit || rs2_exe_hit);
    assign redirect     = hz.exe_taken || hz.exe_jal;
    assign flush_active = redirect || (flush_left_q != 2'd0);

    // ------------------------------------------------------------------
    // Combinational pipeline controls
    // ------------------------------------------------------------------
    // Younger instructions are discarded on a redirect, so stalling them is
    // pointless. The flush takes priority.
    assign hz.stall_if_id  = load_use && !flush_active;
    assign hz.flush_if_id  = flush_active;
    assign hz.flush_id_exe = flush_active || load_use;

    assign hz.fwd_a     = fwd_a_q;
    assign hz.fwd_b     = fwd_b_q;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every target gets a default at the top of the block, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        mem_wen_d    = hz.exe_wen;
        mem_waddr_d  = hz.exe_waddr;
        flush_left_d = flush_left_q;
        fwd_a_d      = FWD_RF;
        fwd_b_d      = FWD_RF;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;

        // A redirect restarts the window. It does not add to what is left.
        if (redirect) begin
            flush_left_d = FLUSH_RELOAD;
        end else if (flush_left_q != 2'd0) begin
            flush_left_d = flush_left_q - 2'd1;
        end

        // A bubble or an empty ID slot reaches EXE with no operands to forward.
        if (hz.id_valid && !hz.flush_id_exe) begin
            fwd_a_d = fwd_sel(rs1_exe_hit, rs1_mem_hit, hz.exe_memread);
            fwd_b_d = fwd_sel(rs2_exe_hit, rs2_mem_hit, hz.exe_memread);
        end

        if (hz.stall_if_id && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CSIZE'(1);
        end
        if (redirect && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CSIZE'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments, so
    // every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_wen_q    <= 1'b0;
            mem_waddr_q  <= '0;
            flush_left_q <= 2'd0;
            fwd_a_q      <= FWD_RF;
            fwd_b_q      <= FWD_RF;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            mem_wen_q    <= mem_wen_d;
            mem_waddr_q  <= mem_waddr_d;
            flush_left_q <= flush_left_d;
            fwd_a_q      <= fwd_a_d;
            fwd_b_q      <= fwd_b_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//   Directed scenarios followed by a randomized run. Every cycle, a reference
//   model built from the hazard rules checks all DUT outputs.
//   The model tracks how long ago the last redirect happened. It also keeps the
//   previous cycle's EXE fields and integer event totals clipped to the
//   counter range.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

    localparam int ASIZE    = 5;
    localparam int BR_FLUSH = 2;
    localparam int CSIZE    = 4;
    localparam int CNT_SAT  = (1 << CSIZE) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hazard_unit_if #(.ASIZE(ASIZE), .CSIZE(CSIZE)) hz_if ();

    hazard_unit #(
        .ASIZE   (ASIZE),
        .BR_FLUSH(BR_FLUSH),
        .CSIZE   (CSIZE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz_if)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int         m_since;      // cycles since last redirect edge (large = none)
    bit         m_prev_wen;   // EXE fields seen at the previous edge
    logic [4:0] m_prev_waddr;
    logic [1:0] m_fwd_a;
    logic [1:0] m_fwd_b;
    int         m_stalls;
    int         m_flushes;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit depends(input logic used, input logic [4:0] rs,
                                   input logic wen, input logic [4:0] waddr);
        return used && wen && (waddr == rs) && (rs != 5'd0);
    endfunction

    function automatic logic [1:0] pick(input bit exe_hit, input bit mem_hit,
                                        input bit exe_load);
        if (exe_hit && !exe_load) return 2'b01;
        if (mem_hit)              return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_since      = 1000;
        m_prev_wen   = 1'b0;
        m_prev_waddr = '0;
        m_fwd_a      = 2'b00;
        m_fwd_b      = 2'b00;
        m_stalls     = 0;
        m_flushes    = 0;
    endtask

    task automatic idle();
        rst                = 1'b1;
        hz_if.id_valid     = 1'b0;
        hz_if.id_rs1       = '0;
        hz_if.id_rs2       = '0;
        hz_if.id_rs1_used  = 1'b0;
        hz_if.id_rs2_used  = 1'b0;
        hz_if.exe_waddr    = '0;
        hz_if.exe_wen      = 1'b0;
        hz_if.exe_memread  = 1'b0;
        hz_if.exe_taken    = 1'b0;
        hz_if.exe_jal      = 1'b0;
    endtask

    // One clock: check every output mid-cycle against the model, then advance
    // the model at the edge. Inputs are changed only after the edge (+1).
    task automatic cycle();
        bit e1, e2, q1, q2, lu, rd, fl;
        logic [1:0] na, nb;
        @(negedge clk);
        e1 = depends(hz_if.id_rs1_used, hz_if.id_rs1, hz_if.exe_wen, hz_if.exe_waddr);
        e2 = depends(hz_if.id_rs2_used, hz_if.id_rs2, hz_if.exe_wen, hz_if.exe_waddr);
        q1 = depends(hz_if.id_rs1_used, hz_if.id_rs1, m_prev_wen, m_prev_waddr);
        q2 = depends(hz_if.id_rs2_used, hz_if.id_rs2, m_prev_wen, m_prev_waddr);
        rd = hz_if.exe_taken || hz_if.exe_jal;
        fl = rd || (m_since < BR_FLUSH);
        lu = hz_if.id_valid && hz_if.exe_memread && (e1 || e2);

        check("stall_if_id",  hz_if.stall_if_id,  lu && !fl);
        check("flush_if_id",  hz_if.flush_if_id,  fl);
        check("flush_id_exe", hz_if.flush_id_exe, fl || lu);
        check("fwd_a",        hz_if.fwd_a,        m_fwd_a);
        check("fwd_b",        hz_if.fwd_b,        m_fwd_b);
        check("stall_cnt",    hz_if.stall_cnt,    (m_stalls  > CNT_SAT) ? CNT_SAT : m_stalls);
        check("flush_cnt",    hz_if.flush_cnt,    (m_flushes > CNT_SAT) ? CNT_SAT : m_flushes);

        na = (!hz_if.id_valid || fl || lu) ? 2'b00 : pick(e1, q1, hz_if.exe_memread);
        nb = (!hz_if.id_valid || fl || lu) ? 2'b00 : pick(e2, q2, hz_if.exe_memread);

        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            m_stalls     += (lu && !fl) ? 1 : 0;
            m_flushes    += rd ? 1 : 0;
            m_since       = rd ? 1 : ((m_since < 1000) ? m_since + 1 : m_since);
            m_prev_wen    = hz_if.exe_wen;
            m_prev_waddr  = hz_if.exe_waddr;
            m_fwd_a       = na;
            m_fwd_b       = nb;
        end
        #1;
    endtask

    initial begin
        model_reset();
        idle();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state with idle inputs
        cycle();
        check("rst_fwd_a",     hz_if.fwd_a,     2'b00);
        check("rst_stall_cnt", hz_if.stall_cnt, 0);
        check("rst_flush_cnt", hz_if.flush_cnt, 0);
        rst = 1'b1;

        // lw r3 in EXE, add reading r3 in ID
        hz_if.exe_wen = 1'b1; hz_if.exe_memread = 1'b1; hz_if.exe_waddr = 5'd3;
        hz_if.id_valid = 1'b1;
        hz_if.id_rs1 = 5'd3; hz_if.id_rs1_used = 1'b1;
        hz_if.id_rs2 = 5'd7; hz_if.id_rs2_used = 1'b1;
        #1;
        check("lu_stall",    hz_if.stall_if_id,  1'b1);
        check("lu_bubble",   hz_if.flush_id_exe, 1'b1);
        cycle();
        hz_if.exe_wen = 1'b0; hz_if.exe_memread = 1'b0; hz_if.exe_waddr = 5'd0;
        #1;
        check("lu_released", hz_if.stall_if_id,  1'b0);
        cycle();
        check("lu_fwd_a",     hz_if.fwd_a,     2'b10);
        check("lu_stall_cnt", hz_if.stall_cnt, 1);

        // add r4 in EXE, sub reading r4 as rs2
        hz_if.exe_wen = 1'b1; hz_if.exe_waddr = 5'd4;
        hz_if.id_rs1 = 5'd9; hz_if.id_rs2 = 5'd4;
        cycle();
        check("alu_fwd_b", hz_if.fwd_b, 2'b01);
        check("alu_fwd_a", hz_if.fwd_a, 2'b00);

        // r5 produced in both EXE and MEM: EXE wins
        hz_if.exe_waddr = 5'd5; hz_if.id_valid = 1'b0;
        cycle();
        hz_if.id_valid = 1'b1; hz_if.id_rs1 = 5'd5; hz_if.id_rs2 = 5'd9;
        cycle();
        check("prio_fwd_a", hz_if.fwd_a, 2'b01);

        // r0 is never a dependency
        hz_if.exe_waddr = 5'd0; hz_if.exe_memread = 1'b1;
        hz_if.id_rs1 = 5'd0; hz_if.id_rs2 = 5'd0;
        #1;
        check("r0_stall", hz_if.stall_if_id, 1'b0);
        cycle();
        check("r0_fwd_a", hz_if.fwd_a, 2'b00);

        // Taken branch with a coincident load-use: flush wins, window of 2
        hz_if.exe_waddr = 5'd6; hz_if.exe_taken = 1'b1; hz_if.id_rs1 = 5'd6;
        #1;
        check("br_stall_masked", hz_if.stall_if_id, 1'b0);
        check("br_flush_now",    hz_if.flush_if_id, 1'b1);
        cycle();
        check("br_flush_cnt", hz_if.flush_cnt, 1);
        idle();
        #1;
        check("br_flush_held", hz_if.flush_if_id, 1'b1);
        cycle();
        check("br_flush_done", hz_if.flush_if_id, 1'b0);
        check("br_stall_cnt",  hz_if.stall_cnt,   1);

        // Randomized traffic on a small register range so hazards are frequent
        for (int i = 0; i < 3000; i++) begin
            rst               = ($urandom_range(0, 63) != 0);
            hz_if.id_valid    = ($urandom_range(0, 7) != 0);
            hz_if.id_rs1      = 5'($urandom_range(0, 3));
            hz_if.id_rs2      = 5'($urandom_range(0, 3));
            hz_if.id_rs1_used = 1'($urandom);
            hz_if.id_rs2_used = 1'($urandom);
            hz_if.exe_waddr   = 5'($urandom_range(0, 3));
            hz_if.exe_wen     = 1'($urandom);
            hz_if.exe_memread = ($urandom_range(0, 2) == 0);
            hz_if.exe_taken   = ($urandom_range(0, 9) == 0);
            hz_if.exe_jal     = ($urandom_range(0, 19) == 0);
            cycle();
        end

        // Drive stall_cnt into saturation
        idle();
        repeat (3) cycle();
        hz_if.exe_wen = 1'b1; hz_if.exe_memread = 1'b1; hz_if.exe_waddr = 5'd2;
        hz_if.id_valid = 1'b1; hz_if.id_rs2 = 5'd2; hz_if.id_rs2_used = 1'b1;
        repeat (20) cycle();
        check("sat_stall_cnt", hz_if.stall_cnt, CNT_SAT);

        // Reset in the middle of a flush window
        idle();
        hz_if.exe_jal = 1'b1;
        cycle();
        idle();
        rst = 1'b0;
        #1;
        check("mid_flush_held", hz_if.flush_if_id, 1'b1);
        cycle();
        rst = 1'b1;
        #1;
        check("mid_flush_drop",  hz_if.flush_if_id,  1'b0);
        check("mid_bubble_drop", hz_if.flush_id_exe, 1'b0);
        check("mid_stall_cnt",   hz_if.stall_cnt,    0);
        check("mid_flush_cnt",   hz_if.flush_cnt,    0);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
